// File: rtl/de_pipe_buffer.sv
// Decode/Execute buffer: two-entry (main + skid) valid/ready register with flush; accepted data is visible the cycle after the edge.
// in_ready is registered and drops only when both entries are live; ctrl_out is zeroed whenever main is empty.
module de_pipe_buffer #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [ADDR_W-1:0] wadd_in,
  input  logic [FUNC_W-1:0] func_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [ADDR_W-1:0] wadd_out,
  output logic [FUNC_W-1:0] func_out
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] wadd;
    logic [FUNC_W-1:0] func;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t state_q, state_d;
  ent_t   main_q, main_d;
  ent_t   skid_q, skid_d;
  ent_t   in_ent;
  logic   accept, take;

  assign in_ent    = {ctrl_in, rd1_in, rd2_in, wadd_in, func_in};
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload fields are left untouched so the data outputs keep their last value.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = in_ent;
          end
        end
        HALF: begin
          if (accept && take) begin
            main_d = in_ent;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_ent;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_d = HALF;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Bubbles carry no control so no write-back or I/O side-effect reaches Execute.
  assign ctrl_out = out_valid ? main_q.ctrl : '0;
  assign rd1_out  = main_q.rd1;
  assign rd2_out  = main_q.rd2;
  assign wadd_out = main_q.wadd;
  assign func_out = main_q.func;

endmodule

// File: tb/tb_de_pipe_buffer.sv
// Scoreboard bench for de_pipe_buffer: directed stimulus pushes expected entries, a negedge monitor checks each take.
module tb_de_pipe_buffer;

  typedef struct packed {
    logic [10:0] ctrl;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [2:0]  wadd;
    logic [2:0]  func;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] ctrl_in;
  logic [15:0] rd1_in, rd2_in;
  logic [2:0]  wadd_in, func_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] ctrl_out;
  logic [15:0] rd1_out, rd2_out;
  logic [2:0]  wadd_out, func_out;

  item_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  de_pipe_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .wadd_in(wadd_in), .func_in(func_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .wadd_out(wadd_out), .func_out(func_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an instruction; it is expected downstream only if this edge will accept it.
  task automatic send(input item_t it);
    in_valid = 1'b1;
    ctrl_in  = it.ctrl;
    rd1_in   = it.rd1;
    rd2_in   = it.rd2;
    wadd_in  = it.wadd;
    func_in  = it.func;
    if (in_ready && !flush) q.push_back(it);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      item_t act;
      item_t exp;
      act = {ctrl_out, rd1_out, rd2_out, wadd_out, func_out};
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL take_unexpected: got ctrl=%h rd1=%h with nothing expected at %0t",
                 ctrl_out, rd1_out, $time);
      end else begin
        exp = q.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL take_order: got ctrl=%h rd1=%h rd2=%h wadd=%h func=%h expected ctrl=%h rd1=%h rd2=%h wadd=%h func=%h at %0t",
                   act.ctrl, act.rd1, act.rd2, act.wadd, act.func,
                   exp.ctrl, exp.rd1, exp.rd2, exp.wadd, exp.func, $time);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t a, b, c, d, f1, f2, r1, r2, r3, v;
    a  = '{ctrl: 11'h7FF, rd1: 16'h1234, rd2: 16'hABCD, wadd: 3'd5, func: 3'd3};
    b  = '{ctrl: 11'h155, rd1: 16'h5678, rd2: 16'h0F0F, wadd: 3'd2, func: 3'd6};
    c  = '{ctrl: 11'h2AA, rd1: 16'h9ABC, rd2: 16'hF00D, wadd: 3'd7, func: 3'd1};
    d  = '{ctrl: 11'h0F0, rd1: 16'hDDDD, rd2: 16'h4444, wadd: 3'd4, func: 3'd4};
    f1 = '{ctrl: 11'h111, rd1: 16'h1111, rd2: 16'h2222, wadd: 3'd1, func: 3'd2};
    f2 = '{ctrl: 11'h222, rd1: 16'h3333, rd2: 16'h4444, wadd: 3'd3, func: 3'd5};
    r1 = '{ctrl: 11'h321, rd1: 16'hAAAA, rd2: 16'hBBBB, wadd: 3'd6, func: 3'd7};
    r2 = '{ctrl: 11'h456, rd1: 16'hCCCC, rd2: 16'hDDDD, wadd: 3'd2, func: 3'd1};
    r3 = '{ctrl: 11'h0AB, rd1: 16'h0101, rd2: 16'h0202, wadd: 3'd3, func: 3'd6};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; rd1_in = '0; rd2_in = '0; wadd_in = '0; func_in = '0;

    // Reset values, visible before any clock edge.
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("rst_rd1_out", 32'(rd1_out), 32'd0);
    tick();
    rst_n = 1'b1;

    // Stream A then B with Execute always ready.
    out_ready = 1'b1;
    send(a);
    tick();
    chk("stream_a_valid", 32'(out_valid), 32'd1);
    chk("stream_a_rd1", 32'(rd1_out), 32'h1234);
    chk("stream_a_ctrl", 32'(ctrl_out), 32'h7FF);
    chk("stream_a_in_ready", 32'(in_ready), 32'd1);
    send(b);
    tick();
    chk("stream_b_valid", 32'(out_valid), 32'd1);
    chk("stream_b_rd1", 32'(rd1_out), 32'h5678);
    chk("stream_b_in_ready", 32'(in_ready), 32'd1);
    idle();
    tick();
    chk("bubble1_valid", 32'(out_valid), 32'd0);
    chk("bubble1_ctrl", 32'(ctrl_out), 32'd0);
    chk("bubble1_rd1_hold", 32'(rd1_out), 32'h5678);

    // Stall fill: A in main, B into skid, C held off until space frees.
    out_ready = 1'b0;
    send(a);
    tick();
    send(b);
    tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_rd1_is_a", 32'(rd1_out), 32'h1234);
    send(c);
    tick();
    chk("stall_rd1_hold", 32'(rd1_out), 32'h1234);
    chk("stall_ctrl_hold", 32'(ctrl_out), 32'h7FF);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(c);
    tick();
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    chk("unstall_rd1_is_b", 32'(rd1_out), 32'h5678);
    send(c);
    tick();
    chk("unstall_rd1_is_c", 32'(rd1_out), 32'h9ABC);
    idle();
    tick();
    chk("bubble2_valid", 32'(out_valid), 32'd0);
    chk("bubble2_ctrl", 32'(ctrl_out), 32'd0);
    chk("bubble2_rd1_hold", 32'(rd1_out), 32'h9ABC);

    // Flush while FULL, with D offered in the same cycle.
    out_ready = 1'b0;
    send(f1);
    tick();
    send(f2);
    tick();
    chk("pre_flush_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    q.delete();
    send(d);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_ctrl", 32'(ctrl_out), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_d_dropped", 32'(out_valid), 32'd0);

    // Back-to-back accept and take, values 1..8.
    for (int i = 1; i <= 8; i++) begin
      v = '{ctrl: 11'(i), rd1: 16'(i), rd2: 16'(i * 16), wadd: 3'(i), func: 3'(i + 1)};
      send(v);
      tick();
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      chk("b2b_rd1", 32'(rd1_out), 32'(i));
    end
    idle();
    tick();
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    send(r1);
    tick();
    send(r2);
    tick();
    idle();
    chk("pre_arst_full", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_ctrl", 32'(ctrl_out), 32'd0);
    chk("arst_data", 32'({rd1_out, rd2_out} != 32'd0), 32'd0);
    chk("arst_wadd_func", 32'({wadd_out, func_out}), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(r3);
    tick();
    chk("post_arst_rd1", 32'(rd1_out), 32'h0101);
    idle();
    tick();
    chk("post_arst_alone", 32'(out_valid), 32'd0);

    tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
